// File: rtl/scan_select_sequencer_if.sv
// Control and decoder-select bundle between a scan controller and scan_select_sequencer.
// The master drives the requests and the slave (the sequencer) drives select/status.
interface scan_select_sequencer_if #(
  parameter int DWELL_W = 8,
  parameter int SEL_W   = 3
);
  localparam int NUM_CH = 2 ** SEL_W;

  logic               start;
  logic               stop;
  logic               mode_once;
  logic [NUM_CH-1:0]  ch_mask;
  logic [DWELL_W-1:0] dwell;
  logic [SEL_W-1:0]   sel;
  logic               sel_en;
  logic               busy;
  logic               pass_done;
  logic               err_empty;

  modport master (
    output start, stop, mode_once, ch_mask, dwell,
    input  sel, sel_en, busy, pass_done, err_empty
  );

  modport slave (
    input  start, stop, mode_once, ch_mask, dwell,
    output sel, sel_en, busy, pass_done, err_empty
  );
endinterface

// File: rtl/scan_select_sequencer.sv
// Drives select/enable of a one-hot decoder: walks the channels set in a mask,
// holding each for dwell+1 cycles with one blank cycle between channels.
module scan_select_sequencer #(
  parameter int DWELL_W = 8,
  parameter int SEL_W   = 3
) (
  input logic                   clk,
  input logic                   rst,
  scan_select_sequencer_if.slave bus
);
  localparam int NUM_CH = 2 ** SEL_W;

  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [NUM_CH-1:0]  mask_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               once_q;
  logic [SEL_W-1:0]   sel_q;
  logic               sel_en_q;
  logic               busy_q;
  logic               pass_done_q;
  logic               err_q;

  logic [SEL_W-1:0]   nxt_sel;
  logic [SEL_W-1:0]   idx;
  logic               nxt_wrap;

  function automatic logic [SEL_W-1:0] lowest_set(input logic [NUM_CH-1:0] m);
    lowest_set = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (m[i]) lowest_set = SEL_W'(i);
    end
  endfunction

  // Circular search from sel+1; smallest offset wins, so iterate offsets high to low.
  // Landing at or below the current channel means the pass has wrapped.
  always_comb begin
    nxt_sel = sel_q;
    idx     = '0;
    for (int i = NUM_CH - 1; i >= 1; i--) begin
      idx = sel_q + SEL_W'(i);
      if (mask_q[idx]) nxt_sel = idx;
    end
    nxt_wrap = (nxt_sel <= sel_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      mask_q      <= '0;
      dwell_q     <= '0;
      once_q      <= 1'b0;
      sel_q       <= '0;
      sel_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      pass_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      pass_done_q <= 1'b0;
      err_q       <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.stop) begin
            if (bus.ch_mask == '0) begin
              err_q <= 1'b1;
            end else begin
              mask_q   <= bus.ch_mask;
              dwell_q  <= bus.dwell;
              once_q   <= bus.mode_once;
              sel_q    <= lowest_set(bus.ch_mask);
              cnt      <= bus.dwell;
              sel_en_q <= 1'b1;
              busy_q   <= 1'b1;
              state    <= ACTIVE;
            end
          end
        end
        ACTIVE: begin
          if (bus.stop) begin
            sel_en_q <= 1'b0;
            busy_q   <= 1'b0;
            state    <= IDLE;
          end else if (cnt == '0) begin
            // pass_done is registered, so it is decided here to appear during GAP.
            sel_en_q    <= 1'b0;
            pass_done_q <= nxt_wrap;
            state       <= GAP;
          end else begin
            cnt <= cnt - DWELL_W'(1);
          end
        end
        GAP: begin
          if (bus.stop || (nxt_wrap && once_q)) begin
            busy_q <= 1'b0;
            state  <= IDLE;
          end else begin
            sel_q    <= nxt_sel;
            cnt      <= dwell_q;
            sel_en_q <= 1'b1;
            state    <= ACTIVE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sel       = sel_q;
  assign bus.sel_en    = sel_en_q;
  assign bus.busy      = busy_q;
  assign bus.pass_done = pass_done_q;
  assign bus.err_empty = err_q;
endmodule
